// File: rtl/pid_pkg.sv
// Shared types, widths and sign-magnitude helpers for the multi-channel PID.
// WIDTH is fixed here so the conversion helpers and the datapath agree on it.
package pid_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned ACC_W = 2*WIDTH + 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MUL_P,
      MUL_I,
      MUL_D,
      ACC,
      DONE
   } state_t;

   // Negative zero maps to 0.
   function automatic logic signed [WIDTH-1:0] signmag_to_twos(input logic [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] mag;
      mag = signed'({1'b0, x[WIDTH-2:0]});
      return x[WIDTH-1] ? -mag : mag;
   endfunction

   // Zero always comes out with a clear sign bit.
   function automatic logic [WIDTH-1:0] twos_to_signmag(input logic signed [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] mag;
      mag = (x < 0) ? -x : x;
      return {x[WIDTH-1], mag[WIDTH-2:0]};
   endfunction

endpackage

// File: rtl/pid_sat.sv
// Combinational symmetric clamp to +/-LIM at full input width, with a clamp flag.
// The result is narrowed to OW bits, which always holds since |LIM| fits OW.
module pid_sat #(
   parameter int unsigned W   = 66,
   parameter int unsigned OW  = 32,
   parameter int unsigned LIM = 1000
) (
   input  logic signed [W-1:0]  value,
   output logic signed [OW-1:0] clamped_c,
   output logic                 hit_c
);

   localparam logic signed [W-1:0] POS = W'(LIM);
   localparam logic signed [W-1:0] NEG = -POS;

   always_comb begin
      hit_c     = (value > POS) || (value < NEG);
      clamped_c = OW'((value > POS) ? POS : ((value < NEG) ? NEG : value));
   end

endmodule

// File: rtl/pid_multi.sv
// Time-multiplexed PID over CHANNELS loops sharing one multiplier; five cycles per channel.
// Ports are sign-magnitude, the datapath is two's complement.
module pid_multi
   import pid_pkg::*;
#(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned FRAC     = 8,
   parameter int unsigned INT_LIM  = 1000,
   parameter int unsigned OUT_MAX  = 10000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      start_calc,
   input  logic [CHANNELS-1:0]       int_clr,
   input  logic [CHANNELS*WIDTH-1:0] error,
   input  logic [CHANNELS*WIDTH-1:0] kp,
   input  logic [CHANNELS*WIDTH-1:0] ki,
   input  logic [CHANNELS*WIDTH-1:0] kd,
   input  logic [WIDTH-1:0]          delta_t,
   output logic [CHANNELS*WIDTH-1:0] pid_out,
   output logic [CHANNELS-1:0]       sat,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned OP_W = WIDTH + 1;
   localparam logic [CH_W-1:0] LAST = CH_W'(CHANNELS - 1);

   state_t                  state, state_next;
   logic [CH_W-1:0]         ch;
   logic signed [WIDTH-1:0] e_snap [CHANNELS];
   logic signed [WIDTH-1:0] integ  [CHANNELS];
   logic signed [WIDTH-1:0] e_prev [CHANNELS];
   logic signed [ACC_W-1:0] acc;
   logic [WIDTH-1:0]        kp_a [CHANNELS];
   logic [WIDTH-1:0]        ki_a [CHANNELS];
   logic [WIDTH-1:0]        kd_a [CHANNELS];
   logic signed [OP_W-1:0]  op_a;
   logic [WIDTH-1:0]        op_b;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] int_sum;
   logic signed [ACC_W-1:0] acc_shr;
   logic signed [WIDTH-1:0] int_clamped;
   logic signed [WIDTH-1:0] out_clamped;
   logic                    int_hit;
   logic                    out_hit;

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         kp_a[c] = kp[c*WIDTH +: WIDTH];
         ki_a[c] = ki[c*WIDTH +: WIDTH];
         kd_a[c] = kd[c*WIDTH +: WIDTH];
      end
   end

   // Shared multiplier: signed data operand times zero-extended unsigned gain/step.
   always_comb begin
      op_a = OP_W'(e_snap[ch]);
      op_b = delta_t;
      case (state)
         MUL_P: op_b = kp_a[ch];
         MUL_I: begin
            op_a = OP_W'(integ[ch]);
            op_b = ki_a[ch];
         end
         MUL_D: begin
            op_a = OP_W'(e_snap[ch]) - OP_W'(e_prev[ch]);
            op_b = kd_a[ch];
         end
         default: ;
      endcase
      prod = ACC_W'(op_a) * ACC_W'(signed'({1'b0, op_b}));
   end

   assign int_sum = ACC_W'(integ[ch]) + prod;
   assign acc_shr = acc >>> FRAC;

   pid_sat #(.W(ACC_W), .OW(WIDTH), .LIM(INT_LIM)) u_int_sat (
      .value     (int_sum),
      .clamped_c (int_clamped),
      .hit_c     (int_hit)
   );

   pid_sat #(.W(ACC_W), .OW(WIDTH), .LIM(OUT_MAX)) u_out_sat (
      .value     (acc_shr),
      .clamped_c (out_clamped),
      .hit_c     (out_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_calc && en) state_next = LOAD;
         LOAD:    state_next = MUL_P;
         MUL_P:   state_next = MUL_I;
         MUL_I:   state_next = MUL_D;
         MUL_D:   state_next = ACC;
         ACC:     state_next = (ch == LAST) ? DONE : LOAD;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered status; busy/done follow the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch      <= '0;
         acc     <= '0;
         pid_out <= '0;
         sat     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            e_snap[c] <= '0;
            integ[c]  <= '0;
            e_prev[c] <= '0;
         end
      end else begin
         busy <= (state_next != IDLE);
         done <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (start_calc && en) begin
                  ch <= '0;
                  for (int c = 0; c < CHANNELS; c++) begin
                     e_snap[c] <= signmag_to_twos(error[c*WIDTH +: WIDTH]);
                     if (int_clr[c]) begin
                        integ[c]  <= '0;
                        e_prev[c] <= '0;
                     end
                  end
               end
            end
            LOAD:         integ[ch] <= int_hit ? int_clamped : WIDTH'(int_sum);
            MUL_P:        acc <= prod;
            MUL_I, MUL_D: acc <= acc + prod;
            ACC: begin
               pid_out[ch*WIDTH +: WIDTH] <= twos_to_signmag(out_clamped);
               sat[ch]                    <= out_hit;
               e_prev[ch]                 <= e_snap[ch];
               if (ch != LAST) ch <= ch + CH_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pid_multi.sv
// Directed bench for pid_multi: hand-computed vectors per feature, three channels, WIDTH 32.
module tb_pid_multi;

   localparam int W = 32;
   localparam int N = 3;

   logic           clk = 1'b0;
   logic           rst, en, start_calc;
   logic [N-1:0]   int_clr;
   logic [N*W-1:0] error, kp, ki, kd;
   logic [W-1:0]   delta_t;
   logic [N*W-1:0] pid_out;
   logic [N-1:0]   sat;
   logic           busy, done;

   int n_vec = 0;
   int n_bad = 0;

   pid_multi dut (
      .clk(clk), .rst(rst), .en(en), .start_calc(start_calc), .int_clr(int_clr),
      .error(error), .kp(kp), .ki(ki), .kd(kd), .delta_t(delta_t),
      .pid_out(pid_out), .sat(sat), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] out_of(input int c);
      return pid_out[c*W +: W];
   endfunction

   task automatic set_ch(input int c, input logic [W-1:0] p, input logic [W-1:0] i,
                         input logic [W-1:0] d, input logic [W-1:0] e);
      kp[c*W +: W]    = p;
      ki[c*W +: W]    = i;
      kd[c*W +: W]    = d;
      error[c*W +: W] = e;
   endtask

   task automatic clear_all;
      kp = '0; ki = '0; kd = '0; error = '0; int_clr = '0;
   endtask

   // Pulse start and wait for done; lat is the edge index of done (start edge = 0).
   task automatic run_sweep(output int lat, output bit busy_ok);
      lat = -1;
      busy_ok = 1'b1;
      @(negedge clk); start_calc = 1'b1;
      @(negedge clk); start_calc = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
      n_vec++;
      if (lat < 0) begin
         n_bad++;
         $display("FAIL sweep_timeout: no done within 100 cycles");
      end
   endtask

   task automatic test_reset;
      n_vec++;
      if ({pid_out, sat, busy, done} !== '0) begin
         n_bad++;
         $display("FAIL reset_state got out=%0h sat=%0b busy=%0b done=%0b want all 0",
                  pid_out, sat, busy, done);
      end
   endtask

   task automatic test_proportional;
      int lat; bit bok;
      clear_all; delta_t = 32'd1;
      set_ch(0, 32'd256, 32'd0, 32'd0, 32'd1000);
      run_sweep(lat, bok);
      n_vec++; if (out_of(0) !== 32'd1000) begin n_bad++; $display("FAIL p_pos got %0h want %0h", out_of(0), 32'd1000); end
      n_vec++; if (sat[0] !== 1'b0) begin n_bad++; $display("FAIL p_pos_sat got %0b want 0", sat[0]); end
      n_vec++; if (lat !== 15) begin n_bad++; $display("FAIL done_latency got %0d want 15", lat); end
      n_vec++; if (bok !== 1'b1) begin n_bad++; $display("FAIL busy_window got %0b want 1", bok); end
      @(negedge clk);
      n_vec++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL after_done got busy=%0b done=%0b want 0 0", busy, done); end
      set_ch(0, 32'd512, 32'd0, 32'd0, 32'h8000_01F4);
      run_sweep(lat, bok);
      n_vec++; if (out_of(0) !== 32'h8000_03E8) begin n_bad++; $display("FAIL p_neg got %0h want %0h", out_of(0), 32'h8000_03E8); end
   endtask

   task automatic test_integrator;
      int lat; bit bok;
      clear_all; delta_t = 32'd1;
      set_ch(1, 32'd0, 32'd256, 32'd0, 32'd100);
      for (int k = 1; k <= 3; k++) begin
         run_sweep(lat, bok);
         n_vec++;
         if (out_of(1) !== 32'(100*k)) begin n_bad++; $display("FAIL i_accum%0d got %0h want %0h", k, out_of(1), 32'(100*k)); end
      end
      int_clr = 3'b010;
      run_sweep(lat, bok);
      int_clr = '0;
      n_vec++; if (out_of(1) !== 32'd100) begin n_bad++; $display("FAIL i_clear got %0h want %0h", out_of(1), 32'd100); end
      set_ch(1, 32'd0, 32'd256, 32'd0, 32'd600);
      int_clr = 3'b010;
      run_sweep(lat, bok);
      int_clr = '0;
      n_vec++; if (out_of(1) !== 32'd600) begin n_bad++; $display("FAIL i_600 got %0h want %0h", out_of(1), 32'd600); end
      run_sweep(lat, bok);
      n_vec++; if (out_of(1) !== 32'd1000) begin n_bad++; $display("FAIL i_clamp got %0h want %0h", out_of(1), 32'd1000); end
      n_vec++; if (sat[1] !== 1'b0) begin n_bad++; $display("FAIL i_clamp_sat got %0b want 0", sat[1]); end
      set_ch(1, 32'd0, 32'd256, 32'd0, 32'h8000_0258);
      run_sweep(lat, bok);
      n_vec++; if (out_of(1) !== 32'd400) begin n_bad++; $display("FAIL i_unwind got %0h want %0h", out_of(1), 32'd400); end
   endtask

   task automatic test_derivative;
      int lat; bit bok;
      logic [W-1:0] errs [3];
      logic [W-1:0] exps [3];
      errs = '{32'd100, 32'd150, 32'd150};
      exps = '{32'd100, 32'd50, 32'd0};
      clear_all;
      for (int k = 0; k < 3; k++) begin
         set_ch(2, 32'd0, 32'd0, 32'd256, errs[k]);
         run_sweep(lat, bok);
         n_vec++;
         if (out_of(2) !== exps[k]) begin n_bad++; $display("FAIL d_step%0d got %0h want %0h", k, out_of(2), exps[k]); end
      end
   endtask

   task automatic test_saturation;
      int lat; bit bok;
      logic [W-1:0] errs [3];
      logic [W-1:0] exps [3];
      logic         sats [3];
      errs = '{32'd20000, 32'h8000_4E20, 32'd5};
      exps = '{32'd10000, 32'h8000_2710, 32'd5};
      sats = '{1'b1, 1'b1, 1'b0};
      clear_all;
      for (int k = 0; k < 3; k++) begin
         set_ch(0, 32'd256, 32'd0, 32'd0, errs[k]);
         run_sweep(lat, bok);
         n_vec++;
         if (out_of(0) !== exps[k] || sat[0] !== sats[k]) begin
            n_bad++;
            $display("FAIL sat_case%0d got out=%0h sat=%0b want out=%0h sat=%0b", k, out_of(0), sat[0], exps[k], sats[k]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int cnt = 0;
      @(negedge clk); start_calc = 1'b1;
      @(negedge clk); start_calc = 1'b0;
      repeat (3) @(negedge clk);
      start_calc = 1'b1;
      @(negedge clk); start_calc = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) cnt++;
      end
      n_vec++; if (cnt !== 1) begin n_bad++; $display("FAIL start_while_busy got %0d done pulses want 1", cnt); end
      n_vec++; if (out_of(0) !== 32'd5) begin n_bad++; $display("FAIL b2b_out got %0h want %0h", out_of(0), 32'd5); end
   endtask

   task automatic test_enable;
      int act = 0;
      en = 1'b0;
      @(negedge clk); start_calc = 1'b1;
      @(negedge clk); start_calc = 1'b0;
      if (busy !== 1'b0) act++;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) act++;
      end
      en = 1'b1;
      n_vec++; if (act !== 0) begin n_bad++; $display("FAIL en_low got %0d active cycles want 0", act); end
   endtask

   task automatic test_neg_zero;
      int lat; bit bok;
      clear_all;
      set_ch(0, 32'd256, 32'd0, 32'd0, 32'h8000_0000);
      run_sweep(lat, bok);
      n_vec++; if (out_of(0) !== 32'd0) begin n_bad++; $display("FAIL neg_zero got %0h want 0", out_of(0)); end
   endtask

   task automatic test_reset_mid;
      int lat; bit bok;
      clear_all;
      set_ch(0, 32'd256, 32'd0, 32'd0, 32'd5);
      run_sweep(lat, bok);
      n_vec++; if (out_of(0) !== 32'd5) begin n_bad++; $display("FAIL pre_reset got %0h want %0h", out_of(0), 32'd5); end
      set_ch(1, 32'd0, 32'd256, 32'd0, 32'd100);
      @(negedge clk); start_calc = 1'b1;
      @(negedge clk); start_calc = 1'b0;
      repeat (7) @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %0b want 1", busy); end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({pid_out, sat, busy, done} !== '0) begin
         n_bad++;
         $display("FAIL async_reset got out=%0h sat=%0b busy=%0b done=%0b want all 0", pid_out, sat, busy, done);
      end
      @(negedge clk); rst = 1'b0;
      run_sweep(lat, bok);
      n_vec++; if (out_of(1) !== 32'd100) begin n_bad++; $display("FAIL post_reset_i got %0h want %0h", out_of(1), 32'd100); end
      n_vec++; if (out_of(0) !== 32'd5) begin n_bad++; $display("FAIL post_reset_p got %0h want %0h", out_of(0), 32'd5); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; start_calc = 1'b0; delta_t = '0;
      clear_all;
      #2;
      test_reset;
      @(negedge clk); rst = 1'b0;
      test_proportional;
      test_integrator;
      test_derivative;
      test_saturation;
      test_back_to_back;
      test_enable;
      test_neg_zero;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pid_multi.md
Name: pid_multi

Overview:
- Time-multiplexed, parametrised PID controller serving CHANNELS independent loops (roll/pitch/yaw by default) with one shared multiplier.
- Successor to the single-channel PID. Adds per-channel gains, an integrator clamp (anti-windup), output saturation with flags, integrator clear, and a busy flag.
- Port-level values are sign-magnitude (bit WIDTH-1 = sign). Internal arithmetic is two's complement.
- Sits between the error/setpoint stage and the motor mixer.

Parameters:
- WIDTH, 32, word width of every error, gain and output field.
- CHANNELS, 3, number of control loops.
- FRAC, 8, fractional bits of Kp/Ki/Kd; the sum of products is arithmetic-shifted right by FRAC.
- INT_LIM, 1000, magnitude clamp applied to each integrator accumulator.
- OUT_MAX, 10000, magnitude clamp applied to each pid_out channel.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  when 0, start_calc is ignored in IDLE; a sweep already running completes
- start_calc  in  1  single-cycle request to run one sweep over all channels
- int_clr  in  CHANNELS  per-channel integrator and e_prev clear, sampled on the start edge
- error  in  CHANNELS*WIDTH  per-channel error, sign-magnitude, snapshotted on the start edge
- kp, ki, kd  in  CHANNELS*WIDTH  unsigned per-channel gains, UQ(WIDTH-FRAC).FRAC; held stable while busy
- delta_t  in  WIDTH  unsigned integration step; held stable while busy
- pid_out  out  CHANNELS*WIDTH  per-channel output, sign-magnitude
- sat  out  CHANNELS  1 = that channel's last output was clamped
- busy  out  1  high from the start edge until done
- done  out  1  one-cycle pulse; all pid_out values are valid

Behaviour:
- Reset (async, rst=1): state IDLE; pid_out, sat, busy, done, integrators, e_prev and snapshot all 0. A reset mid-sweep aborts the sweep; no partial outputs are kept.
- States:
  - IDLE -> LOAD on a posedge with start_calc & en. This edge snapshots error, applies int_clr and sets busy.
  - Per channel: LOAD -> MUL_P -> MUL_I -> MUL_D -> ACC, one cycle each.
  - ACC -> LOAD for the next channel, or -> DONE after channel CHANNELS-1.
  - DONE -> IDLE. done=1 for exactly this cycle; busy drops at the DONE->IDLE edge.
- Latency: taking the start-sampling edge as edge 0, done registers high at edge 5*CHANNELS (edge 15 for CHANNELS=3).
- start_calc while busy is ignored. No queuing.
- Channel c math, using e = twos(error[c]):
  - LOAD: I[c] = clamp(I[c] + e*delta_t, +/-INT_LIM).
  - MUL_P: acc = Kp*e.
  - MUL_I: acc += Ki*I[c].
  - MUL_D: acc += Kd*(e - e_prev[c]). delta_t is folded into Kd.
  - ACC: y = acc >>> FRAC (arithmetic); pid_out[c] = signmag(clamp(y, +/-OUT_MAX)); sat[c] = clamp active; e_prev[c] = e.
- Width rules:
  - Products are 2*WIDTH signed; the accumulator is 2*WIDTH+2 bits.
  - All clamps compare at full width; no silent wrap anywhere.
- Anti-windup: the integrator is clamped before multiplication, so it unwinds immediately when e reverses.
- Sign-magnitude negative zero {1,0} is read as 0. Outputs never emit negative zero.
- pid_out and sat hold their values between sweeps and update per channel at that channel's ACC edge.
- int_clr[c]=1 on the start edge zeroes I[c] and e_prev[c] before that sweep's LOAD for channel c.

Decomposition:
- Package pid_pkg:
  - state enum (IDLE, LOAD, MUL_P, MUL_I, MUL_D, ACC, DONE)
  - functions signmag_to_twos and twos_to_signmag, parametrised by WIDTH
  - localparam ACC_W = 2*WIDTH+2
- Sub-module pid_sat: a combinational signed clamp to +/-LIM that also outputs a clamp flag. Instantiated twice, once for the integrator clamp and once for the output clamp.
- The FSM, channel counter and shared multiplier stay in pid_multi.

Test Plan:
- Proportional only, ch0: Kp=256, Ki=Kd=0, error=+1000 -> pid_out[0]=1000, sat[0]=0. done pulses exactly at edge 15 and busy is high over edges 0-15. Also: error={1,500} with Kp=512 -> pid_out[0]={1,1000}.
- Integrator only, ch1: Ki=256, delta_t=1, error=+100.
  - Three sweeps -> 100, 200, 300.
  - Sweep with int_clr[1]=1 -> 100.
  - With INT_LIM=1000 and error=600: two sweeps -> 600, then 1000 (clamped).
  - Next sweep with error={1,600} -> 400.
- Derivative only, ch2: Kd=256, errors 100 then 150 -> outputs 100, then 50. Third sweep with error 150 -> 0.
- Output saturation: Kp=256.
  - error=20000 -> pid_out=10000, sat=1.
  - error={1,20000} -> {1,10000}, sat=1.
  - error=5 -> 5, sat=0.
- Control and edge cases:
  - start_calc pulsed at edge 4 of a sweep -> ignored; only one done pulse.
  - en=0 with start_calc -> no busy.
  - Negative zero input -> pid_out=0 with sign bit 0.
- Reset mid-sweep: rst asserted between edges 7 and 8 -> busy, done, pid_out, sat drop to 0 immediately (async). A following sweep with Ki=256, error=100 gives 100, proving the integrators were cleared.
